// File: rtl/cu_pkg.sv
// Shared encodings for the microsequenced control unit: micro-PC states,
// ALU function codes, instruction opcodes and the packed control word.
package cu_pkg;

  localparam logic [2:0] PC_IDX  = 3'd7;
  localparam logic [2:0] PSW_IDX = 3'd6;
  localparam logic [2:0] RET_IDX = 3'd5;

  typedef enum logic [4:0] {
    S_CHECK  = 5'd0,
    S_F1     = 5'd1,
    S_F2     = 5'd2,
    S_F3     = 5'd3,
    S_F4     = 5'd4,
    S_DECODE = 5'd5,
    S_ALU1   = 5'd6,
    S_ALU2   = 5'd7,
    S_ALU3   = 5'd8,
    S_SH1    = 5'd9,
    S_SH2    = 5'd10,
    S_SH3    = 5'd11,
    S_LD1    = 5'd12,
    S_LD2    = 5'd13,
    S_LD3    = 5'd14,
    S_ST1    = 5'd15,
    S_ST2    = 5'd16,
    S_ST3    = 5'd17,
    S_BR1    = 5'd18,
    S_BR2    = 5'd19,
    S_BR3    = 5'd20,
    S_JMP1   = 5'd21,
    S_LDI1   = 5'd22,
    S_JMP2   = 5'd23,
    S_INT1   = 5'd24,
    S_INT2   = 5'd25,
    S_INT3   = 5'd26,
    S_INT4   = 5'd27,
    S_INT5   = 5'd28,
    S_HALT   = 5'd29,
    S_LDI2   = 5'd30,
    S_UNUSED = 5'd31
  } upc_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5
  } alu_op_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_LOAD  = 4'h8,
    OP_STORE = 4'h9,
    OP_BZ    = 4'hA,
    OP_BN    = 4'hB,
    OP_BNZ   = 4'hC,
    OP_JMP   = 4'hD,
    OP_LDI   = 4'hE,
    OP_HALT  = 4'hF
  } opcode_t;

  typedef struct packed {
    logic [2:0] alu;
    logic [2:0] gpr_sel;
    logic       con_rom_out;
    logic       gpr_in;
    logic       gpr_out;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       psw_in;
    logic       psw_out;
    logic       ram_rd;
    logic       ram_wr;
    logic       timer_in;
    logic       y_in;
    logic       y_out;
    logic       y_offset_in;
    logic       y_shl;
    logic       y_shr;
    logic       z_in;
    logic       z_out;
  } ctrl_t;

endpackage

// File: rtl/cu_microrom.sv
// Control-word decode for each micro-PC state. Purely combinational; the
// low opcode bits and Rs2 are stable for the whole execute phase.
module cu_microrom
  import cu_pkg::*;
(
  input  upc_t       upc,
  input  logic [2:0] op_lo,
  input  logic [2:0] ir_rs2,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (upc)
      S_F1:   begin ctrl.gpr_sel = PC_IDX; ctrl.gpr_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.y_in = 1'b1; end
      S_F2:   begin ctrl.ram_rd = 1'b1; ctrl.mdr_in = 1'b1; ctrl.con_rom_out = 1'b1;
                    ctrl.alu = ALU_ADD; ctrl.z_in = 1'b1; end
      S_F3:   begin ctrl.z_out = 1'b1; ctrl.gpr_sel = PC_IDX; ctrl.gpr_in = 1'b1; end
      S_F4:   begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
      S_ALU1: begin ctrl.gpr_sel = ir_rs2; ctrl.gpr_out = 1'b1; ctrl.y_in = 1'b1; end
      // ALU opcodes 1..5 map directly onto the ALU function codes.
      S_ALU2: begin ctrl.gpr_out = 1'b1; ctrl.alu = op_lo; ctrl.z_in = 1'b1; ctrl.psw_in = 1'b1; end
      S_ALU3: begin ctrl.z_out = 1'b1; ctrl.gpr_in = 1'b1; end
      S_SH1:  begin ctrl.gpr_sel = ir_rs2; ctrl.gpr_out = 1'b1; ctrl.y_in = 1'b1; end
      S_SH2:  begin ctrl.y_shl = ~op_lo[0]; ctrl.y_shr = op_lo[0]; end
      S_SH3:  begin ctrl.y_out = 1'b1; ctrl.gpr_sel = ir_rs2; ctrl.gpr_in = 1'b1; end
      S_LD1:  begin ctrl.gpr_sel = ir_rs2; ctrl.gpr_out = 1'b1; ctrl.mar_in = 1'b1; end
      S_LD2:  begin ctrl.ram_rd = 1'b1; ctrl.mdr_in = 1'b1; end
      S_LD3:  begin ctrl.mdr_out = 1'b1; ctrl.gpr_in = 1'b1; end
      S_ST1:  begin ctrl.gpr_sel = ir_rs2; ctrl.gpr_out = 1'b1; ctrl.mar_in = 1'b1; end
      S_ST2:  begin ctrl.gpr_out = 1'b1; ctrl.mdr_in = 1'b1; end
      S_ST3:  begin ctrl.ram_wr = 1'b1; end
      S_BR1:  begin ctrl.y_offset_in = 1'b1; end
      S_BR2:  begin ctrl.gpr_sel = PC_IDX; ctrl.gpr_out = 1'b1; ctrl.alu = ALU_ADD; ctrl.z_in = 1'b1; end
      S_BR3:  begin ctrl.z_out = 1'b1; ctrl.gpr_sel = PC_IDX; ctrl.gpr_in = 1'b1; end
      S_JMP1: begin ctrl.gpr_sel = ir_rs2; ctrl.gpr_out = 1'b1; ctrl.y_in = 1'b1; end
      S_JMP2: begin ctrl.y_out = 1'b1; ctrl.gpr_sel = PC_IDX; ctrl.gpr_in = 1'b1; end
      S_LDI1: begin ctrl.y_offset_in = 1'b1; end
      S_LDI2: begin ctrl.y_out = 1'b1; ctrl.gpr_sel = ir_rs2; ctrl.gpr_in = 1'b1; end
      // Interrupt entry: save PSW and PC, then vector PC and reload timer/PSW.
      S_INT1: begin ctrl.psw_out = 1'b1; ctrl.gpr_sel = PSW_IDX; ctrl.gpr_in = 1'b1; end
      S_INT2: begin ctrl.gpr_sel = PC_IDX; ctrl.gpr_out = 1'b1; ctrl.y_in = 1'b1; end
      S_INT3: begin ctrl.y_out = 1'b1; ctrl.gpr_sel = RET_IDX; ctrl.gpr_in = 1'b1; end
      S_INT4: begin ctrl.con_rom_out = 1'b1; ctrl.gpr_sel = PC_IDX; ctrl.gpr_in = 1'b1;
                    ctrl.timer_in = 1'b1; end
      S_INT5: begin ctrl.con_rom_out = 1'b1; ctrl.psw_in = 1'b1; end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore microsequencer: the micro-PC selects the control word; next-state
// logic branches only at CHECK (interrupt) and DECODE (opcode / flags).
module control_unit
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [2:0] PSW_bits,
  input  logic [2:0] IR_Rs2,
  input  logic       timeout,
  output logic [4:0] REG_OUT_CONTROL_UNIT,
  output logic [2:0] ALU_control,
  output logic [2:0] GPR_select,
  output logic       con_ROM_out,
  output logic       GPR_in,
  output logic       GPR_out,
  output logic       IR_in,
  output logic       MAR_in,
  output logic       MDR_in,
  output logic       MDR_out,
  output logic       PSW_in,
  output logic       PSW_out,
  output logic       RAM_enable_read,
  output logic       RAM_enable_write,
  output logic       timer_in,
  output logic       Y_in,
  output logic       Y_out,
  output logic       Y_offset_in,
  output logic       Y_shift_left,
  output logic       Y_shift_right,
  output logic       Z_in,
  output logic       Z_out
);

  upc_t  upc_q;
  upc_t  upc_d;
  ctrl_t ctrl;
  logic  flag_z;
  logic  flag_n;
  logic  int_en;

  assign flag_z = PSW_bits[0];
  assign flag_n = PSW_bits[1];
  assign int_en = PSW_bits[2];

  always_comb begin
    upc_d = S_CHECK;
    case (upc_q)
      S_CHECK:  upc_d = (timeout && int_en) ? S_INT1 : S_F1;
      S_F1:     upc_d = S_F2;
      S_F2:     upc_d = S_F3;
      S_F3:     upc_d = S_F4;
      S_F4:     upc_d = S_DECODE;
      S_DECODE: begin
        case (opcode_t'(opcode))
          OP_NOP:                                    upc_d = S_CHECK;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:     upc_d = S_ALU1;
          OP_SHL, OP_SHR:                            upc_d = S_SH1;
          OP_LOAD:                                   upc_d = S_LD1;
          OP_STORE:                                  upc_d = S_ST1;
          OP_BZ:                                     upc_d = flag_z  ? S_BR1 : S_CHECK;
          OP_BN:                                     upc_d = flag_n  ? S_BR1 : S_CHECK;
          OP_BNZ:                                    upc_d = !flag_z ? S_BR1 : S_CHECK;
          OP_JMP:                                    upc_d = S_JMP1;
          OP_LDI:                                    upc_d = S_LDI1;
          OP_HALT:                                   upc_d = S_HALT;
          default:                                   upc_d = S_CHECK;
        endcase
      end
      S_ALU1:   upc_d = S_ALU2;
      S_ALU2:   upc_d = S_ALU3;
      S_SH1:    upc_d = S_SH2;
      S_SH2:    upc_d = S_SH3;
      S_LD1:    upc_d = S_LD2;
      S_LD2:    upc_d = S_LD3;
      S_ST1:    upc_d = S_ST2;
      S_ST2:    upc_d = S_ST3;
      S_BR1:    upc_d = S_BR2;
      S_BR2:    upc_d = S_BR3;
      S_JMP1:   upc_d = S_JMP2;
      S_LDI1:   upc_d = S_LDI2;
      S_INT1:   upc_d = S_INT2;
      S_INT2:   upc_d = S_INT3;
      S_INT3:   upc_d = S_INT4;
      S_INT4:   upc_d = S_INT5;
      // HALT is left only through reset.
      S_HALT:   upc_d = S_HALT;
      default:  upc_d = S_CHECK;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upc_q <= S_CHECK;
    end else begin
      upc_q <= upc_d;
    end
  end

  cu_microrom u_microrom (
    .upc    (upc_q),
    .op_lo  (opcode[2:0]),
    .ir_rs2 (IR_Rs2),
    .ctrl   (ctrl)
  );

  assign REG_OUT_CONTROL_UNIT = upc_q;
  assign ALU_control          = ctrl.alu;
  assign GPR_select           = ctrl.gpr_sel;
  assign con_ROM_out          = ctrl.con_rom_out;
  assign GPR_in               = ctrl.gpr_in;
  assign GPR_out              = ctrl.gpr_out;
  assign IR_in                = ctrl.ir_in;
  assign MAR_in               = ctrl.mar_in;
  assign MDR_in               = ctrl.mdr_in;
  assign MDR_out              = ctrl.mdr_out;
  assign PSW_in               = ctrl.psw_in;
  assign PSW_out              = ctrl.psw_out;
  assign RAM_enable_read      = ctrl.ram_rd;
  assign RAM_enable_write     = ctrl.ram_wr;
  assign timer_in             = ctrl.timer_in;
  assign Y_in                 = ctrl.y_in;
  assign Y_out                = ctrl.y_out;
  assign Y_offset_in          = ctrl.y_offset_in;
  assign Y_shift_left         = ctrl.y_shl;
  assign Y_shift_right        = ctrl.y_shr;
  assign Z_in                 = ctrl.z_in;
  assign Z_out                = ctrl.z_out;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios followed by random
// instructions, compared cycle by cycle against a per-instruction state-trace model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode = '0;
  logic [2:0] PSW_bits = '0;
  logic [2:0] IR_Rs2 = '0;
  logic       timeout = 1'b0;
  logic [4:0] REG_OUT_CONTROL_UNIT;
  logic [2:0] ALU_control, GPR_select;
  logic con_ROM_out, GPR_in, GPR_out, IR_in, MAR_in, MDR_in, MDR_out, PSW_in, PSW_out;
  logic RAM_enable_read, RAM_enable_write, timer_in, Y_in, Y_out, Y_offset_in;
  logic Y_shift_left, Y_shift_right, Z_in, Z_out;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .PSW_bits(PSW_bits), .IR_Rs2(IR_Rs2),
    .timeout(timeout), .REG_OUT_CONTROL_UNIT(REG_OUT_CONTROL_UNIT),
    .ALU_control(ALU_control), .GPR_select(GPR_select), .con_ROM_out(con_ROM_out),
    .GPR_in(GPR_in), .GPR_out(GPR_out), .IR_in(IR_in), .MAR_in(MAR_in), .MDR_in(MDR_in),
    .MDR_out(MDR_out), .PSW_in(PSW_in), .PSW_out(PSW_out),
    .RAM_enable_read(RAM_enable_read), .RAM_enable_write(RAM_enable_write),
    .timer_in(timer_in), .Y_in(Y_in), .Y_out(Y_out), .Y_offset_in(Y_offset_in),
    .Y_shift_left(Y_shift_left), .Y_shift_right(Y_shift_right), .Z_in(Z_in), .Z_out(Z_out)
  );

  always #5 clk = ~clk;

  localparam int I_CON = 18, I_GIN = 17, I_GOUT = 16, I_IRIN = 15, I_MAR = 14;
  localparam int I_MDRIN = 13, I_MDROUT = 12, I_PSWIN = 11, I_PSWOUT = 10, I_RD = 9;
  localparam int I_WR = 8, I_TMR = 7, I_YIN = 6, I_YOUT = 5, I_YOFF = 4, I_SHL = 3;
  localparam int I_SHR = 2, I_ZIN = 1, I_ZOUT = 0;

  logic [24:0] obs_vec;
  assign obs_vec = {ALU_control, GPR_select, con_ROM_out, GPR_in, GPR_out, IR_in, MAR_in,
                    MDR_in, MDR_out, PSW_in, PSW_out, RAM_enable_read, RAM_enable_write,
                    timer_in, Y_in, Y_out, Y_offset_in, Y_shift_left, Y_shift_right,
                    Z_in, Z_out};

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  logic [3:0] cur_op = '0;
  logic [2:0] cur_rs2 = '0;

  // Expected control word of each state, written straight from the state table.
  function automatic logic [24:0] exp_out(input int s, input logic [3:0] op, input logic [2:0] rs2);
    logic [18:0] st;
    logic [2:0]  alu;
    logic [2:0]  sel;
    st = '0; alu = 3'd0; sel = 3'd0;
    case (s)
      1:  begin sel = 3'd7; st[I_GOUT] = 1; st[I_MAR] = 1; st[I_YIN] = 1; end
      2:  begin st[I_RD] = 1; st[I_MDRIN] = 1; st[I_CON] = 1; alu = 3'b001; st[I_ZIN] = 1; end
      3:  begin st[I_ZOUT] = 1; sel = 3'd7; st[I_GIN] = 1; end
      4:  begin st[I_MDROUT] = 1; st[I_IRIN] = 1; end
      6:  begin sel = rs2; st[I_GOUT] = 1; st[I_YIN] = 1; end
      7:  begin st[I_GOUT] = 1; alu = op[2:0]; st[I_ZIN] = 1; st[I_PSWIN] = 1; end
      8:  begin st[I_ZOUT] = 1; st[I_GIN] = 1; end
      9:  begin sel = rs2; st[I_GOUT] = 1; st[I_YIN] = 1; end
      10: begin if (op == 4'h6) st[I_SHL] = 1; else st[I_SHR] = 1; end
      11: begin st[I_YOUT] = 1; sel = rs2; st[I_GIN] = 1; end
      12: begin sel = rs2; st[I_GOUT] = 1; st[I_MAR] = 1; end
      13: begin st[I_RD] = 1; st[I_MDRIN] = 1; end
      14: begin st[I_MDROUT] = 1; st[I_GIN] = 1; end
      15: begin sel = rs2; st[I_GOUT] = 1; st[I_MAR] = 1; end
      16: begin st[I_GOUT] = 1; st[I_MDRIN] = 1; end
      17: begin st[I_WR] = 1; end
      18: begin st[I_YOFF] = 1; end
      19: begin sel = 3'd7; st[I_GOUT] = 1; alu = 3'b001; st[I_ZIN] = 1; end
      20: begin st[I_ZOUT] = 1; sel = 3'd7; st[I_GIN] = 1; end
      21: begin sel = rs2; st[I_GOUT] = 1; st[I_YIN] = 1; end
      22: begin st[I_YOFF] = 1; end
      23: begin st[I_YOUT] = 1; sel = 3'd7; st[I_GIN] = 1; end
      24: begin st[I_PSWOUT] = 1; sel = 3'd6; st[I_GIN] = 1; end
      25: begin sel = 3'd7; st[I_GOUT] = 1; st[I_YIN] = 1; end
      26: begin st[I_YOUT] = 1; sel = 3'd5; st[I_GIN] = 1; end
      27: begin st[I_CON] = 1; sel = 3'd7; st[I_GIN] = 1; st[I_TMR] = 1; end
      28: begin st[I_CON] = 1; st[I_PSWIN] = 1; end
      30: begin st[I_YOUT] = 1; sel = rs2; st[I_GIN] = 1; end
      default: ;
    endcase
    return {alu, sel, st};
  endfunction

  // Whole state trace an instruction should walk, starting from state 0.
  task automatic build_seq(input logic [3:0] op, input logic [2:0] psw, input logic to);
    bit taken;
    exp_q.delete();
    if (to && psw[2]) begin
      for (int s = 24; s <= 28; s++) exp_q.push_back(s);
      exp_q.push_back(0);
      return;
    end
    for (int s = 1; s <= 5; s++) exp_q.push_back(s);
    taken = (op == 4'hA && psw[0]) || (op == 4'hB && psw[1]) || (op == 4'hC && !psw[0]);
    if (op >= 4'h1 && op <= 4'h5)      begin exp_q.push_back(6);  exp_q.push_back(7);  exp_q.push_back(8);  end
    else if (op == 4'h6 || op == 4'h7) begin exp_q.push_back(9);  exp_q.push_back(10); exp_q.push_back(11); end
    else if (op == 4'h8)               begin exp_q.push_back(12); exp_q.push_back(13); exp_q.push_back(14); end
    else if (op == 4'h9)               begin exp_q.push_back(15); exp_q.push_back(16); exp_q.push_back(17); end
    else if (taken)                    begin exp_q.push_back(18); exp_q.push_back(19); exp_q.push_back(20); end
    else if (op == 4'hD)               begin exp_q.push_back(21); exp_q.push_back(23); end
    else if (op == 4'hE)               begin exp_q.push_back(22); exp_q.push_back(30); end
    if (op == 4'hF && !(to && psw[2])) exp_q.push_back(29);
    else exp_q.push_back(0);
  endtask

  task automatic check_state(input int s, input string tag);
    logic [24:0] ev;
    ev = exp_out(s, cur_op, cur_rs2);
    vectors++;
    assert (REG_OUT_CONTROL_UNIT === 5'(s)) else begin
      miscompares++;
      $error("FAIL %s upc: got %0d want %0d", tag, REG_OUT_CONTROL_UNIT, s);
    end
    vectors++;
    assert (obs_vec === ev) else begin
      miscompares++;
      $error("FAIL %s ctrl@%0d: got %h want %h", tag, s, obs_vec, ev);
    end
  endtask

  // Runs one instruction from state 0; stops early once state abort_at is checked.
  task automatic run_instr(input logic [3:0] op, input logic [2:0] rs2, input logic [2:0] psw,
                           input logic to, input int abort_at, input string tag);
    int s;
    cur_op = op; cur_rs2 = rs2;
    opcode = op; IR_Rs2 = rs2; PSW_bits = psw; timeout = to;
    build_seq(op, psw, to);
    $display("instr %s op=%h rs2=%0d psw=%b to=%b states=%0d", tag, op, rs2, psw, to, exp_q.size());
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      @(posedge clk); #1;
      check_state(s, tag);
      if (s == abort_at) return;
      // Flags are only looked at in CHECK and DECODE; disturb them elsewhere.
      if (s >= 6 && exp_q.size() > 0) begin
        PSW_bits = 3'($urandom_range(0, 7));
        timeout  = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check_state(0, {tag, "_async"});
    repeat (2) @(posedge clk);
    #1;
    check_state(0, {tag, "_held"});
    timeout = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    $display("reset %s released", tag);
  endtask

  initial begin
    logic [3:0] op;
    #1;
    check_state(0, "por");
    do_reset("init");

    run_instr(4'h0, 3'd0, 3'b000, 1'b0, -1, "nop_fetch");
    run_instr(4'h1, 3'd3, 3'b000, 1'b0, -1, "add");
    run_instr(4'hA, 3'd1, 3'b001, 1'b0, -1, "bz_taken");
    run_instr(4'hA, 3'd1, 3'b000, 1'b0, -1, "bz_not");
    run_instr(4'h1, 3'd2, 3'b100, 1'b1, -1, "interrupt");
    run_instr(4'h6, 3'd4, 3'b000, 1'b0, -1, "shl");
    run_instr(4'h7, 3'd5, 3'b000, 1'b0, -1, "shr");
    run_instr(4'hB, 3'd1, 3'b010, 1'b0, -1, "bn_taken");
    run_instr(4'hC, 3'd1, 3'b001, 1'b0, -1, "bnz_not");
    run_instr(4'hD, 3'd6, 3'b000, 1'b0, -1, "jmp");
    run_instr(4'hE, 3'd2, 3'b000, 1'b1, -1, "ldi_to_no_ie");

    run_instr(4'hF, 3'd0, 3'b000, 1'b0, -1, "halt");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_state(29, "halt_hold");
    end
    do_reset("halt");

    run_instr(4'h8, 3'd3, 3'b000, 1'b0, 13, "load_abort");
    do_reset("mid13");
    run_instr(4'h9, 3'd1, 3'b000, 1'b0, -1, "store_after_rst");

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                ($urandom_range(0, 5) == 0), -1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
